gty_quad_reset_sequencer: RTL and testbench

GTY_QUAD_RESET_SEQUENCER -- requirements
Module: gty_quad_reset_sequencer

---
 rtl/gty_seq_pkg.sv | 24 ++
 rtl/gty_status_sync.sv | 28 ++
 rtl/gty_quad_reset_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_gty_quad_reset_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gty_seq_pkg.sv
// Shared definitions for the GTY quad reset sequencer: FSM states,
// fail-stage codes and the width of the shared hold/wait timer.
package gty_seq_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_QPLL_RST,
    S_QPLL_WAIT,
    S_TX_RST,
    S_TX_WAIT,
    S_RX_RST,
    S_RX_WAIT,
    S_DONE,
    S_FAIL
  } gty_state_e;

  localparam logic [1:0] FS_NONE = 2'd0;
  localparam logic [1:0] FS_QPLL = 2'd1;
  localparam logic [1:0] FS_TX   = 2'd2;
  localparam logic [1:0] FS_RX   = 2'd3;

endpackage

// File: rtl/gty_status_sync.sv
// Parameterised-width two-flop synchronizer for transceiver status bits
// (QPLL lock, TX/RX reset-done) that arrive from other clock domains.
module gty_status_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture; both stages clear to 0 so status reads "not ready" after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/gty_quad_reset_sequencer.sv
// Reset sequencer for a group of GTY quads: QPLL reset, then TX reset, then
// RX reset, each held for a fixed width and followed by a timed wait for the
// matching lock/done bits, with bounded retries and a sticky FAIL state.
module gty_quad_reset_sequencer
  import gty_seq_pkg::*;
#(
  parameter int NUM_QUADS      = 2,
  parameter int CH_PER_QUAD    = 4,
  parameter int HOLD_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [NUM_QUADS*CH_PER_QUAD-1:0] ch_en_i,
  input  logic [NUM_QUADS-1:0]             qpll_lock_i,
  input  logic [NUM_QUADS*CH_PER_QUAD-1:0] tx_resetdone_i,
  input  logic [NUM_QUADS*CH_PER_QUAD-1:0] rx_resetdone_i,
  output logic [NUM_QUADS-1:0]             qpll_reset_o,
  output logic [NUM_QUADS*CH_PER_QUAD-1:0] gttx_reset_o,
  output logic [NUM_QUADS*CH_PER_QUAD-1:0] gtrx_reset_o,
  output logic                             ready_o,
  output logic                             busy_o,
  output logic                             fail_o,
  output logic [1:0]                       fail_stage_o,
  output logic [1:0]                       retry_cnt_o
);

  localparam int TOTAL_CH = NUM_QUADS * CH_PER_QUAD;
  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]         RETRY_MAX = 2'(MAX_RETRIES);

  gty_state_e           r_state, w_state_nxt, w_adv;
  logic [TIMER_W-1:0]   r_timer;
  logic                 w_timer_clr;
  logic [TOTAL_CH-1:0]  r_ch_en, w_ch_en_nxt;
  logic [NUM_QUADS-1:0] w_quad_en, w_quad_en_nxt;
  logic [1:0]           r_retry, w_retry_nxt;
  logic [1:0]           r_fail_stage, w_fail_stage_nxt;
  logic [1:0]           w_stage;
  logic                 w_wait, w_cond;

  logic [NUM_QUADS-1:0] w_qpll_lock;
  logic [TOTAL_CH-1:0]  w_tx_done, w_rx_done;
  logic                 w_qpll_ok, w_tx_ok, w_rx_ok;

  logic [NUM_QUADS-1:0] r_qpll_rst, w_qpll_rst_nxt;
  logic [TOTAL_CH-1:0]  r_tx_rst, w_tx_rst_nxt;
  logic [TOTAL_CH-1:0]  r_rx_rst, w_rx_rst_nxt;
  logic                 r_ready, r_busy, r_fail;
  logic                 w_all_hold;

  gty_status_sync #(.WIDTH(NUM_QUADS)) u_sync_qpll (
    .clk(clk), .rst(rst), .i_async(qpll_lock_i), .o_sync(w_qpll_lock)
  );
  gty_status_sync #(.WIDTH(TOTAL_CH)) u_sync_tx (
    .clk(clk), .rst(rst), .i_async(tx_resetdone_i), .o_sync(w_tx_done)
  );
  gty_status_sync #(.WIDTH(TOTAL_CH)) u_sync_rx (
    .clk(clk), .rst(rst), .i_async(rx_resetdone_i), .o_sync(w_rx_done)
  );

  // A quad is enabled when any of its channels is enabled (current and next mask).
  always_comb begin
    for (int q = 0; q < NUM_QUADS; q++) begin
      w_quad_en[q]     = |r_ch_en[q*CH_PER_QUAD +: CH_PER_QUAD];
      w_quad_en_nxt[q] = |w_ch_en_nxt[q*CH_PER_QUAD +: CH_PER_QUAD];
    end
  end

  // Disabled lanes never block a wait, so an all-zero mask passes straight through.
  assign w_qpll_ok = &(w_qpll_lock | ~w_quad_en);
  assign w_tx_ok   = &(w_tx_done   | ~r_ch_en);
  assign w_rx_ok   = &(w_rx_done   | ~r_ch_en);

  // Next-state logic; start_i pre-empts everything, wait states share one timeout path.
  always_comb begin
    w_state_nxt      = r_state;
    w_ch_en_nxt      = r_ch_en;
    w_retry_nxt      = r_retry;
    w_fail_stage_nxt = r_fail_stage;
    w_timer_clr      = 1'b0;
    w_wait           = 1'b0;
    w_cond           = 1'b0;
    w_stage          = FS_NONE;
    w_adv            = r_state;
    if (start_i) begin
      w_state_nxt      = S_QPLL_RST;
      w_ch_en_nxt      = ch_en_i;
      w_retry_nxt      = 2'd0;
      w_fail_stage_nxt = FS_NONE;
      w_timer_clr      = 1'b1;
    end else begin
      case (r_state)
        S_IDLE:      w_state_nxt = S_IDLE;
        S_QPLL_RST:  if (r_timer == HOLD_LAST) w_state_nxt = S_QPLL_WAIT;
        S_QPLL_WAIT: begin w_wait = 1'b1; w_cond = w_qpll_ok; w_stage = FS_QPLL; w_adv = S_TX_RST; end
        S_TX_RST:    if (r_timer == HOLD_LAST) w_state_nxt = S_TX_WAIT;
        S_TX_WAIT:   begin w_wait = 1'b1; w_cond = w_tx_ok; w_stage = FS_TX; w_adv = S_RX_RST; end
        S_RX_RST:    if (r_timer == HOLD_LAST) w_state_nxt = S_RX_WAIT;
        S_RX_WAIT:   begin w_wait = 1'b1; w_cond = w_rx_ok; w_stage = FS_RX; w_adv = S_DONE; end
        S_DONE: begin
          if (!w_qpll_ok)    w_state_nxt = S_QPLL_RST;
          else if (!w_rx_ok) w_state_nxt = S_RX_RST;
        end
        S_FAIL:      w_state_nxt = S_FAIL;
        default:     w_state_nxt = S_IDLE;
      endcase
      // Condition beats a coincident timeout.
      if (w_wait) begin
        if (w_cond) begin
          w_state_nxt = w_adv;
        end else if (r_timer == TO_LAST) begin
          w_fail_stage_nxt = w_stage;
          if (r_retry < RETRY_MAX) begin
            w_retry_nxt = r_retry + 2'd1;
            w_state_nxt = S_QPLL_RST;
          end else begin
            w_state_nxt = S_FAIL;
          end
        end
      end
    end
    w_timer_clr = w_timer_clr | (w_state_nxt != r_state);
  end

  // Reset levels for the state being entered; disabled lanes and IDLE/FAIL hold everything in reset.
  always_comb begin
    w_all_hold     = w_state_nxt inside {S_IDLE, S_FAIL};
    w_qpll_rst_nxt = ~w_quad_en_nxt |
                     {NUM_QUADS{w_all_hold || (w_state_nxt == S_QPLL_RST)}};
    w_tx_rst_nxt   = ~w_ch_en_nxt |
                     {TOTAL_CH{w_all_hold || (w_state_nxt inside {S_QPLL_RST, S_QPLL_WAIT, S_TX_RST})}};
    w_rx_rst_nxt   = ~w_ch_en_nxt |
                     {TOTAL_CH{w_all_hold || (w_state_nxt inside {S_QPLL_RST, S_QPLL_WAIT, S_TX_RST,
                                                                    S_TX_WAIT, S_RX_RST})}};
  end

  // FSM state and sequence bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ch_en      <= '0;
      r_retry      <= 2'd0;
      r_fail_stage <= FS_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_ch_en      <= w_ch_en_nxt;
      r_retry      <= w_retry_nxt;
      r_fail_stage <= w_fail_stage_nxt;
    end
  end

  // Shared hold/wait timer: counts cycles spent in the current state, saturating.
  always_ff @(posedge clk) begin
    if (rst || w_timer_clr) begin
      r_timer <= '0;
    end else if (r_timer != '1) begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  // Registered outputs, decoded from the next state so they line up with r_state glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_qpll_rst <= '1;
      r_tx_rst   <= '1;
      r_rx_rst   <= '1;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_qpll_rst <= w_qpll_rst_nxt;
      r_tx_rst   <= w_tx_rst_nxt;
      r_rx_rst   <= w_rx_rst_nxt;
      r_ready    <= (w_state_nxt == S_DONE);
      r_busy     <= !(w_state_nxt inside {S_IDLE, S_DONE, S_FAIL});
      r_fail     <= (w_state_nxt == S_FAIL);
    end
  end

  assign qpll_reset_o = r_qpll_rst;
  assign gttx_reset_o = r_tx_rst;
  assign gtrx_reset_o = r_rx_rst;
  assign ready_o      = r_ready;
  assign busy_o       = r_busy;
  assign fail_o       = r_fail;
  assign fail_stage_o = r_fail_stage;
  assign retry_cnt_o  = r_retry;

endmodule

// File: tb/tb_gty_quad_reset_sequencer.sv
// Bench for gty_quad_reset_sequencer: directed scenarios, a transceiver
// responder that raises lock/done a fixed time after reset release, and a
// phase-level reference model compared against every output each cycle.
module tb_gty_quad_reset_sequencer;

  localparam int NQ   = 2;
  localparam int CPQ  = 4;
  localparam int TC   = NQ * CPQ;
  localparam int HOLD = 64;
  localparam int TO   = 200;
  localparam int MAXR = 3;
  localparam int LAT  = 10;

  logic          clk = 1'b0;
  logic          rst, start_i;
  logic [TC-1:0] ch_en_i;
  logic [NQ-1:0] qpll_lock_i;
  logic [TC-1:0] tx_resetdone_i, rx_resetdone_i;
  logic [NQ-1:0] qpll_reset_o;
  logic [TC-1:0] gttx_reset_o, gtrx_reset_o;
  logic          ready_o, busy_o, fail_o;
  logic [1:0]    fail_stage_o, retry_cnt_o;

  always #5 clk = ~clk;

  gty_quad_reset_sequencer #(
    .NUM_QUADS(NQ), .CH_PER_QUAD(CPQ), .HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ch_en_i(ch_en_i),
    .qpll_lock_i(qpll_lock_i), .tx_resetdone_i(tx_resetdone_i),
    .rx_resetdone_i(rx_resetdone_i), .qpll_reset_o(qpll_reset_o),
    .gttx_reset_o(gttx_reset_o), .gtrx_reset_o(gtrx_reset_o),
    .ready_o(ready_o), .busy_o(busy_o), .fail_o(fail_o),
    .fail_stage_o(fail_stage_o), .retry_cnt_o(retry_cnt_o)
  );

  int tests = 0;
  int fails = 0;
  int nprint = 0;
  int cyc = 0;
  int t_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- transceiver responder ----------------
  logic [NQ-1:0] q_kill = '0;
  logic [TC-1:0] tx_kill = '0, rx_kill = '0;
  int qc[NQ];
  int tc[TC];
  int rc[TC];

  always @(negedge clk) begin
    for (int q = 0; q < NQ; q++) begin
      if (qpll_reset_o[q] === 1'b1) qc[q] = 0;
      else if (qc[q] < LAT) qc[q]++;
      qpll_lock_i[q] = (qc[q] == LAT) && !q_kill[q];
    end
    for (int c = 0; c < TC; c++) begin
      if (gttx_reset_o[c] === 1'b1) tc[c] = 0;
      else if (tc[c] < LAT) tc[c]++;
      tx_resetdone_i[c] = (tc[c] == LAT) && !tx_kill[c];
      if (gtrx_reset_o[c] === 1'b1) rc[c] = 0;
      else if (rc[c] < LAT) rc[c]++;
      rx_resetdone_i[c] = (rc[c] == LAT) && !rx_kill[c];
    end
  end

  // ---------------- reference model ----------------
  // Sequence as numbered steps: even = reset hold, odd = wait, 6 = done.
  bit            m_valid = 0, m_idle = 1, m_failed = 0;
  int            m_step = 0, m_cnt = 0, m_retry = 0, m_fst = 0;
  logic [TC-1:0] m_mask = '0;
  logic [NQ-1:0] qh1 = '0, qh2 = '0;
  logic [TC-1:0] th1 = '0, th2 = '0, rh1 = '0, rh2 = '0;

  function automatic logic [NQ-1:0] qen(input logic [TC-1:0] m);
    logic [NQ-1:0] r;
    for (int q = 0; q < NQ; q++) r[q] = |m[q*CPQ +: CPQ];
    return r;
  endfunction

  always @(posedge clk) begin : model_p
    bit q_ok, t_ok, r_ok, ok;
    if (rst) begin
      m_valid = 1; m_idle = 1; m_failed = 0; m_step = 0; m_cnt = 0;
      m_retry = 0; m_fst = 0; m_mask = '0;
      qh1 = '0; qh2 = '0; th1 = '0; th2 = '0; rh1 = '0; rh2 = '0;
    end else begin
      if (start_i) begin
        m_idle = 0; m_failed = 0; m_step = 0; m_cnt = 0;
        m_retry = 0; m_fst = 0; m_mask = ch_en_i;
      end else if (m_valid && !m_idle && !m_failed) begin
        q_ok = ((qh2 & qen(m_mask)) == qen(m_mask));
        t_ok = ((th2 & m_mask) == m_mask);
        r_ok = ((rh2 & m_mask) == m_mask);
        if (m_step == 6) begin
          if (!q_ok) begin m_step = 0; m_cnt = 0; end
          else if (!r_ok) begin m_step = 4; m_cnt = 0; end
        end else if (m_step % 2 == 0) begin
          if (m_cnt == HOLD - 1) begin m_step++; m_cnt = 0; end
          else m_cnt++;
        end else begin
          ok = (m_step == 1) ? q_ok : (m_step == 3) ? t_ok : r_ok;
          if (ok) begin
            m_step++; m_cnt = 0;
          end else if (m_cnt == TO - 1) begin
            m_fst = (m_step + 1) / 2;
            if (m_retry < MAXR) begin m_retry++; m_step = 0; m_cnt = 0; end
            else m_failed = 1;
          end else begin
            m_cnt++;
          end
        end
      end
      qh2 = qh1; qh1 = qpll_lock_i;
      th2 = th1; th1 = tx_resetdone_i;
      rh2 = rh1; rh1 = rx_resetdone_i;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin : cmp_p
    bit            hi, e_rdy, e_busy, e_fail;
    logic [NQ-1:0] e_q;
    logic [TC-1:0] e_tx, e_rx;
    logic [1:0]    e_retry, e_fst;
    #2;
    if (m_valid) begin
      hi      = m_idle || m_failed;
      e_rdy   = !hi && (m_step == 6);
      e_busy  = !hi && (m_step != 6);
      e_fail  = m_failed;
      e_q     = ~qen(m_mask) | {NQ{hi || (m_step == 0)}};
      e_tx    = ~m_mask | {TC{hi || (m_step <= 2)}};
      e_rx    = ~m_mask | {TC{hi || (m_step <= 4)}};
      e_retry = 2'(m_retry);
      e_fst   = 2'(m_fst);
      tests++;
      if (qpll_reset_o !== e_q || gttx_reset_o !== e_tx || gtrx_reset_o !== e_rx ||
          ready_o !== e_rdy || busy_o !== e_busy || fail_o !== e_fail ||
          retry_cnt_o !== e_retry || fail_stage_o !== e_fst) begin
        fails++;
        if (nprint < 10)
          $display("FAIL model_cycle%0d got/want: q %b/%b tx %h/%h rx %h/%h rdy %b/%b busy %b/%b fail %b/%b retry %0d/%0d stage %0d/%0d",
                   cyc, qpll_reset_o, e_q, gttx_reset_o, e_tx, gtrx_reset_o, e_rx,
                   ready_o, e_rdy, busy_o, e_busy, fail_o, e_fail,
                   retry_cnt_o, e_retry, fail_stage_o, e_fst);
        nprint++;
      end
    end
  end

  // ---------------- edge monitor ----------------
  logic p_q0 = 1'b1, p_t0 = 1'b1, p_r0 = 1'b1;
  int   q_falls = 0, q_rises = 0, t_qf = 0, t_tf = 0, t_rf = 0;
  bit   mon42 = 0, viol42 = 0;

  always @(posedge clk) begin
    #1;
    if (p_q0 === 1'b1 && qpll_reset_o[0] === 1'b0) begin q_falls++; t_qf = cyc; end
    if (p_q0 === 1'b0 && qpll_reset_o[0] === 1'b1) q_rises++;
    if (p_t0 === 1'b1 && gttx_reset_o[0] === 1'b0) t_tf = cyc;
    if (p_r0 === 1'b1 && gtrx_reset_o[0] === 1'b0) t_rf = cyc;
    if (mon42 && (qpll_reset_o[1] !== 1'b1 || gttx_reset_o[7:4] !== 4'hF ||
                  gtrx_reset_o[7:4] !== 4'hF)) viol42 = 1;
    p_q0 = qpll_reset_o[0];
    p_t0 = gttx_reset_o[0];
    p_r0 = gtrx_reset_o[0];
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return ready_o === 1'b1;
      1: return fail_o === 1'b1;
      2: return retry_cnt_o === 2'd2;
      3: return gttx_reset_o[0] === 1'b0;
      default: return gtrx_reset_o[0] === 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int which, input int budget, input string name);
    int n = 0;
    while (!cond(which) && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!cond(which)) begin
      fails++;
      $display("FAIL %s: condition not reached, waited %0d cycles, limit %0d", name, n, budget);
    end
  endtask

  task automatic pulse_start(input logic [TC-1:0] mask);
    @(negedge clk);
    ch_en_i = mask;
    start_i = 1'b1;
    @(posedge clk);
    #1 t_start = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic set_kills(input logic [NQ-1:0] q, input logic [TC-1:0] t, input logic [TC-1:0] r);
    @(posedge clk);
    #3;
    q_kill = q; tx_kill = t; rx_kill = r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int t_low;
    rst = 1'b1; start_i = 1'b0; ch_en_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_qpll_reset", 32'(qpll_reset_o), 32'h3);
    chk("rst_tx_reset",   32'(gttx_reset_o), 32'hFF);
    chk("rst_rx_reset",   32'(gtrx_reset_o), 32'hFF);
    chk("rst_status",     32'({ready_o, busy_o, fail_o, fail_stage_o, retry_cnt_o}), 32'h0);
    // rst wins over a simultaneous start
    start_i = 1'b1; ch_en_i = 8'hFF;
    @(negedge clk);
    start_i = 1'b0;
    chk("rst_over_start_busy", 32'(busy_o), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal full-mask bring-up
    pulse_start(8'hFF);
    wait_until(0, 2000, "nominal_ready");
    chk("nominal_qpll_pulse_width", 32'(t_qf - t_start), 32'd64);
    chk("nominal_order_tx_after_qpll", 32'(t_tf > t_qf), 32'h1);
    chk("nominal_order_rx_after_tx",   32'(t_rf > t_tf), 32'h1);
    chk("nominal_busy_in_done", 32'(busy_o), 32'h0);

    // QPLL lock loss in DONE
    q_rises = 0;
    set_kills(2'b01, '0, '0);
    t_low = -1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ready_o === 1'b0 && t_low < 0) t_low = i;
    end
    chk("lockloss_ready_low_within_4", 32'(t_low >= 0 && t_low <= 4), 32'h1);
    set_kills('0, '0, '0);
    wait_until(0, 2000, "lockloss_back_to_done");
    chk("lockloss_new_qpll_pulse", 32'(q_rises), 32'd1);
    chk("lockloss_retry_unchanged", 32'(retry_cnt_o), 32'd0);

    // RX done loss in DONE re-runs only the RX stage
    set_kills('0, '0, 8'h01);
    repeat (6) @(negedge clk);
    chk("rxloss_rx_reset", 32'(gtrx_reset_o), 32'hFF);
    chk("rxloss_tx_reset_stays_low", 32'(gttx_reset_o), 32'h00);
    chk("rxloss_qpll_reset_stays_low", 32'(qpll_reset_o), 32'h0);
    set_kills('0, '0, '0);
    wait_until(0, 2000, "rxloss_back_to_done");

    // Half mask with quad1 lock dead: quad1 must never matter
    set_kills(2'b10, '0, '0);
    pulse_start(8'h0F);
    viol42 = 0; mon42 = 1;
    wait_until(0, 2000, "halfmask_ready");
    mon42 = 0;
    chk("halfmask_disabled_held_in_reset", 32'(viol42), 32'h0);

    // Full mask with quad1 lock dead: retries exhaust into FAIL
    q_falls = 0;
    pulse_start(8'hFF);
    wait_until(1, 3000, "qpll_timeout_fail");
    chk("qpll_timeout_pulse_count", 32'(q_falls), 32'd4);
    chk("qpll_timeout_fail_stage", 32'(fail_stage_o), 32'd1);
    chk("qpll_timeout_retry_cnt", 32'(retry_cnt_o), 32'd3);
    chk("qpll_timeout_busy", 32'(busy_o), 32'h0);
    repeat (20) @(negedge clk);
    chk("fail_is_sticky", 32'(fail_o), 32'h1);

    // Restart during TX_WAIT with two retries consumed
    set_kills('0, 8'hFF, '0);
    pulse_start(8'hFF);
    wait_until(2, 3000, "txwait_retry2");
    wait_until(3, 1000, "txwait_enter");
    chk("txwait_fail_stage_tx", 32'(fail_stage_o), 32'd2);
    pulse_start(8'hFF);
    chk("restart_qpll_reset", 32'(qpll_reset_o), 32'h3);
    chk("restart_retry_cleared", 32'(retry_cnt_o), 32'd0);
    chk("restart_fail_stage_cleared", 32'(fail_stage_o), 32'd0);
    set_kills('0, '0, '0);
    wait_until(0, 2000, "restart_ready");

    // rst in RX_WAIT
    set_kills('0, '0, 8'hFF);
    pulse_start(8'hFF);
    wait_until(4, 1000, "rxwait_enter");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_qpll_reset", 32'(qpll_reset_o), 32'h3);
    chk("midrst_tx_reset",   32'(gttx_reset_o), 32'hFF);
    chk("midrst_rx_reset",   32'(gtrx_reset_o), 32'hFF);
    chk("midrst_status", 32'({ready_o, busy_o, fail_o}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_kills('0, '0, '0);

    // All-zero mask: fixed latency to DONE
    pulse_start(8'h00);
    wait_until(0, 400, "zeromask_ready");
    chk("zeromask_done_latency", 32'(cyc - t_start), 32'd195);
    chk("zeromask_all_resets_high", 32'({qpll_reset_o, gttx_reset_o, gtrx_reset_o}), 32'h3FFFF);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
